// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response, issue-side window and control.
interface fetch_queue_if;
  logic         fetch_req;
  logic [31:0]  fetch_addr;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic [31:0]  instr1;
  logic [31:0]  instr2;
  logic [31:0]  instr3;
  logic [31:0]  instr4;
  logic [3:0]   instr_valid;
  logic [31:0]  head_pc;
  logic [31:0]  deq_bytes;
  logic         redirect;
  logic [31:0]  redirect_pc;

  // Queue side
  modport master (
    output fetch_req, fetch_addr, instr1, instr2, instr3, instr4, instr_valid, head_pc,
    input  mem_rvalid, mem_rdata, deq_bytes, redirect, redirect_pc
  );

  // Memory / issue-stage side
  modport slave (
    input  fetch_req, fetch_addr, instr1, instr2, instr3, instr4, instr_valid, head_pc,
    output mem_rvalid, mem_rdata, deq_bytes, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches 16-byte blocks into a circular word buffer and presents
// the four oldest words to the issue stage. One outstanding request; redirect flushes.
module fetch_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.master  io_fq
);
  localparam int unsigned AW = $clog2(DEPTH);
  // Highest occupancy that still leaves room for a full block
  localparam logic [AW:0] FillLimit = (AW + 1)'(DEPTH - 4);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [31:0]   r_head_pc;
  logic [31:0]   r_fetch_addr;
  logic [1:0]    r_skip;

  logic          w_fetch_req;
  logic          w_enq;
  logic [2:0]    w_enq_cnt;
  logic [2:0]    w_n;
  logic [3:0]    w_wr_en;
  logic [AW-1:0] w_wr_idx [4];
  logic [31:0]   w_instr [4];
  logic [3:0]    w_valid;
  logic          w_unused;

  // Only the word count of deq_bytes matters
  assign w_unused = ^{io_fq.deq_bytes[31:5], io_fq.deq_bytes[1:0]};

  assign w_fetch_req = !rst && (r_state == StIdle) && !io_fq.redirect && (r_count <= FillLimit);
  assign w_enq       = (r_state == StWait) && io_fq.mem_rvalid && !io_fq.redirect;
  assign w_enq_cnt   = 3'd4 - {1'b0, r_skip};

  // Dequeue count clamped to 4 and to current occupancy
  always_comb begin
    w_n = io_fq.deq_bytes[4:2];
    if (w_n > 3'd4) w_n = 3'd4;
    if ((AW + 1)'(w_n) > r_count) w_n = r_count[2:0];
  end

  // Write slots: response words skip..3 land at consecutive tail positions
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_wr_en[i]  = w_enq && (2'(i) >= r_skip);
      w_wr_idx[i] = r_tail + AW'(i) - AW'(r_skip);
    end
  end

  // Issue window: head..head+3, zero (nop) beyond occupancy
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_valid[k] = r_count > (AW + 1)'(k);
      w_instr[k] = w_valid[k] ? r_mem[r_head + AW'(k)] : 32'b0;
    end
  end

  assign io_fq.fetch_req   = w_fetch_req;
  assign io_fq.fetch_addr  = r_fetch_addr;
  assign io_fq.instr1      = w_instr[0];
  assign io_fq.instr2      = w_instr[1];
  assign io_fq.instr3      = w_instr[2];
  assign io_fq.instr4      = w_instr[3];
  assign io_fq.instr_valid = w_valid;
  assign io_fq.head_pc     = r_head_pc;

  // Fetch FSM next state; redirect overrides everything
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_fetch_req) w_state_next = StWait;
      StWait:  if (io_fq.mem_rvalid) w_state_next = StIdle;
      StDrop:  if (io_fq.mem_rvalid) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (io_fq.redirect) begin
      // A response still in flight must be swallowed before fetching again
      if ((r_state != StIdle) && !io_fq.mem_rvalid) w_state_next = StDrop;
      else w_state_next = StIdle;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Pointers, occupancy, PCs and fetch address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_head_pc    <= RESET_PC;
      r_fetch_addr <= {RESET_PC[31:4], 4'b0};
      r_skip       <= RESET_PC[3:2];
    end else if (io_fq.redirect) begin
      r_count      <= '0;
      r_head       <= r_tail;
      r_head_pc    <= io_fq.redirect_pc;
      r_fetch_addr <= {io_fq.redirect_pc[31:4], 4'b0};
      r_skip       <= io_fq.redirect_pc[3:2];
    end else begin
      r_head    <= r_head + AW'(w_n);
      r_head_pc <= r_head_pc + {27'b0, w_n, 2'b0};
      r_count   <= r_count + (w_enq ? (AW + 1)'(w_enq_cnt) : '0) - (AW + 1)'(w_n);
      if (w_enq) begin
        r_tail       <= r_tail + AW'(w_enq_cnt);
        r_fetch_addr <= r_fetch_addr + 32'd16;
        r_skip       <= 2'b0;
      end
    end
  end

  // Storage array, no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en[i]) r_mem[w_wr_idx[i]] <= io_fq.mem_rdata[32*i +: 32];
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 16, queue capacity in 32-bit instruction words; power of two, >= 8.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fetch_req  output  1  one-cycle request to instruction memory for the 16-byte block at fetch_addr.
REQ-006 fetch_addr  output  32  block address of the request, bits [3:0] always zero.
REQ-007 mem_rvalid  input  1  response for the outstanding request is present on mem_rdata this cycle.
REQ-008 mem_rdata  input  128  four words; word k (address fetch_addr+4k) in bits [32k+31:32k].
REQ-009 Instr1, Instr2, Instr3, Instr4  output  32 each  queue entries head+0..head+3, presented to the pre-decode/issue stage.
REQ-010 instr_valid  output  4  bit k-1 set when InstrK holds a real entry.
REQ-011 head_pc  output  32  byte address of the entry on Instr1.
REQ-012 deq_bytes  input  32  bytes consumed this cycle (issue-stage PCADD); legal values 0, 4, 8, 12, 16.
REQ-013 redirect  input  1  flush queue and restart fetch at redirect_pc.
REQ-014 redirect_pc  input  32  word-aligned restart address.

Function
REQ-015 Storage: circular buffer of DEPTH words, head and tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, occupancy counter 0..DEPTH.
REQ-016 Output slots combinational from head: InstrK = entry (head+K-1) mod DEPTH when K <= occupancy, else 32'b0 (nop); instr_valid thermometer-coded from occupancy, e.g. occupancy 2 -> 4'b0011.
REQ-017 Dequeue count n = deq_bytes[4:2], clamped to min(n, occupancy, 4); deq_bytes[1:0] ignored; head += n, head_pc += 4n.
REQ-018 Fetch FSM states: IDLE, WAIT, DROP.
REQ-019 IDLE: fetch_req = 1 when redirect = 0 and free space (DEPTH - occupancy) >= 4; then -> WAIT, fetch_addr held until response.
REQ-020 WAIT: fetch_req = 0; on mem_rvalid enqueue words skip..3 (skip = start-word offset, 0 except first block after redirect/reset at non-aligned PC), tail += 4-skip, fetch_addr += 16, skip := 0, -> IDLE.
REQ-021 At most one outstanding request; enqueue never overflows because space was checked at request time and dequeue only frees space.
REQ-022 Simultaneous enqueue and dequeue same cycle: occupancy_next = occupancy + enq_count - n.
REQ-023 redirect (any state) has priority: occupancy := 0, head := tail, head_pc := redirect_pc, fetch_addr := {redirect_pc[31:4],4'b0}, skip := redirect_pc[3:2]; dequeue and enqueue that cycle discarded.
REQ-024 redirect in WAIT without same-cycle mem_rvalid -> DROP; in DROP the next mem_rvalid is discarded, then -> IDLE; redirect in WAIT with same-cycle mem_rvalid -> IDLE (data discarded).
REQ-025 redirect in DROP stays in DROP with new fetch_addr/skip; no fetch_req issued in the redirect cycle.
REQ-026 mem_rvalid in IDLE ignored.

Reset
REQ-027 On rst: state IDLE, occupancy 0, head = tail = 0, head_pc = RESET_PC, fetch_addr = {RESET_PC[31:4],4'b0}, skip = RESET_PC[3:2], fetch_req 0, instr_valid 4'b0000, Instr1..4 = 0.
REQ-028 rst asserted mid-WAIT abandons the outstanding request; the first mem_rvalid after rst release while IDLE is ignored.
REQ-029 Storage array contents need not be reset.

Verification
REQ-030 Reset release, RESET_PC 0, memory returns words A0..A3 one cycle after request, deq_bytes 0 -> fetch_req at cycle 1 addr 0, then instr_valid 4'b1111, Instr1 = A0, head_pc 0; fetches continue until occupancy 16, then fetch_req stays 0.
REQ-031 Full queue (16), deq_bytes 8 -> head_pc +8, Instr1 = third word, occupancy 14; no fetch_req until occupancy <= 12.
REQ-032 Occupancy 2, deq_bytes 16 -> clamped to 2, occupancy 0, instr_valid 4'b0000, Instr1..4 = 0; same-cycle mem_rvalid -> occupancy 4.
REQ-033 redirect_pc 0x108 in IDLE -> next request addr 0x100; response W0..W3 enqueues only W2, W3; head_pc 0x108, instr_valid 4'b0011.
REQ-034 redirect during WAIT, response arrives 3 cycles later -> response discarded (occupancy stays 0), FSM DROP->IDLE, next fetch_req at redirect block.
REQ-035 Pointer wrap: run 40 words through with mixed deq_bytes 4/12/16 -> Instr stream equals fetched word order with no loss or duplicate across wrap of head and tail.
